// File: rtl/i2cs_ram_pkg.sv
// Shared types and default widths for the I2C-slave mailbox RAM port controller.
package i2cs_ram_pkg;

  localparam int I2CS_ADDR_W = 8;
  localparam int I2CS_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PTR     = 3'd1,
    ST_WR      = 3'd2,
    ST_RD_LOAD = 3'd3,
    ST_RD_HOLD = 3'd4
  } state_e;

endpackage

// File: rtl/i2cs_ram_ptr.sv
// Loadable wrapping up-counter holding the mailbox RAM pointer; load beats inc.
module i2cs_ram_ptr
  import i2cs_ram_pkg::*;
#(
  parameter int W = I2CS_ADDR_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] r_value;

  // Pointer register: the natural W-bit rollover gives the modulo-2**W wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_value <= '0;
    end else if (load_i) begin
      r_value <= load_val_i;
    end else if (inc_i) begin
      r_value <= r_value + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_value <= r_value;
    end
  end

  assign value_o = r_value;

endmodule

// File: rtl/i2cs_ram_port_ctrl.sv
// Bridges I2C-slave byte events to the 256x8 mailbox RAM (pointer byte, then data bytes).
// Optional write protection of addresses >= WP_BASE is enabled by defining I2CS_RAM_WP_EN.
module i2cs_ram_port_ctrl
  import i2cs_ram_pkg::*;
#(
  parameter int              ADDR_W  = I2CS_ADDR_W,
  parameter int              DATA_W  = I2CS_DATA_W,
  parameter logic [ADDR_W-1:0] WP_BASE = 8'hF0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef I2CS_RAM_WP_EN
  input  logic              wp_i,
  output logic              wp_hit_o,
`endif
  input  logic              xfer_start_i,
  input  logic              xfer_dir_i,
  input  logic              xfer_stop_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              rx_ready_o,
  input  logic              tx_req_i,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_underrun_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              busy_o
);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] w_ptr;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_underrun;
  logic              w_evt_ok;
  logic              w_ptr_load;
  logic              w_rx_wr;
  logic              w_tx_take;
  logic              w_tx_under;
  logic              w_wp_block;

  // Transfer framing always overrides a data event arriving in the same cycle.
  assign w_evt_ok   = !xfer_start_i && !xfer_stop_i;
  assign w_ptr_load = w_evt_ok && rx_valid_i && (r_state == ST_PTR);
  assign w_rx_wr    = w_evt_ok && rx_valid_i && (r_state == ST_WR);
  assign w_tx_take  = w_evt_ok && tx_req_i && (r_state == ST_RD_HOLD);
  assign w_tx_under = w_evt_ok && tx_req_i &&
                      ((r_state == ST_RD_LOAD) || (r_state == ST_IDLE));

`ifdef I2CS_RAM_WP_EN
  logic r_wp_hit;

  assign w_wp_block = wp_i && (w_ptr >= WP_BASE);

  // One-cycle flag for every data byte dropped by write protection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wp_hit <= 1'b0;
    end else begin
      r_wp_hit <= w_rx_wr && w_wp_block;
    end
  end

  assign wp_hit_o = r_wp_hit;
`else
  assign w_wp_block = 1'b0;
`endif

  i2cs_ram_ptr #(.W(ADDR_W)) u_ptr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (w_ptr_load),
    .inc_i      (w_rx_wr || w_tx_take),
    .load_val_i (rx_data_i[ADDR_W-1:0]),
    .value_o    (w_ptr)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: start beats stop, both beat byte-level events.
  always_comb begin
    w_next = r_state;
    if (xfer_start_i) begin
      w_next = xfer_dir_i ? ST_RD_LOAD : ST_PTR;
    end else if (xfer_stop_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_PTR:     w_next = rx_valid_i ? ST_WR : ST_PTR;
        ST_RD_LOAD: w_next = ST_RD_HOLD;
        ST_RD_HOLD: w_next = tx_req_i ? ST_RD_LOAD : ST_RD_HOLD;
        default:    w_next = r_state;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    busy_o     = 1'b1;
    rx_ready_o = 1'b0;
    case (r_state)
      ST_IDLE:       busy_o     = 1'b0;
      ST_PTR, ST_WR: rx_ready_o = 1'b1;
      default:       rx_ready_o = 1'b0;
    endcase
  end

  // Transmit byte holding register; tx_data keeps its last value once invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_tx_under;
      if (!w_evt_ok) begin
        r_tx_valid <= 1'b0;
      end else if (r_state == ST_RD_LOAD) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= ram_rd_data_i;
      end else if (w_tx_take) begin
        r_tx_valid <= 1'b0;
      end else begin
        r_tx_valid <= r_tx_valid;
      end
    end
  end

  assign ram_wr_en_o   = w_rx_wr && !w_wp_block;
  assign ram_wr_addr_o = w_ptr;
  assign ram_wr_data_o = rx_data_i;
  assign ram_rd_addr_o = w_ptr;
  assign ptr_o         = w_ptr;
  assign tx_valid_o    = r_tx_valid;
  assign tx_data_o     = r_tx_data;
  assign tx_underrun_o = r_underrun;

endmodule

// File: tb/tb_i2cs_ram_port_ctrl.sv
// Self-checking bench for i2cs_ram_port_ctrl: transfer-level model plus directed scenarios.
// Define I2CS_RAM_WP_EN to also exercise write protection.
module tb_i2cs_ram_port_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       xfer_start = 1'b0, xfer_dir = 1'b0, xfer_stop = 1'b0;
  logic       rx_valid = 1'b0, tx_req = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready, tx_valid, tx_underrun, ram_wr_en, busy;
  logic [7:0] tx_data, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_data, ptr;
`ifdef I2CS_RAM_WP_EN
  logic       wp = 1'b0;
  logic       wp_hit;
  int         wp_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2cs_ram_port_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
`ifdef I2CS_RAM_WP_EN
    .wp_i          (wp),
    .wp_hit_o      (wp_hit),
`endif
    .xfer_start_i  (xfer_start),
    .xfer_dir_i    (xfer_dir),
    .xfer_stop_i   (xfer_stop),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .rx_ready_o    (rx_ready),
    .tx_req_i      (tx_req),
    .tx_valid_o    (tx_valid),
    .tx_data_o     (tx_data),
    .tx_underrun_o (tx_underrun),
    .ram_wr_en_o   (ram_wr_en),
    .ram_wr_addr_o (ram_wr_addr),
    .ram_wr_data_o (ram_wr_data),
    .ram_rd_addr_o (ram_rd_addr),
    .ram_rd_data_i (ram_rd_data),
    .ptr_o         (ptr),
    .busy_o        (busy)
  );

  function automatic logic [7:0] pat(input int a);
    logic [7:0] v;
    v = a[7:0];
    return v ^ 8'h5A;
  endfunction

  // Mailbox RAM seen by the DUT: write-first, combinational read.
  logic [7:0] ram [256];
  bit         ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
      ram_init <= 1'b1;
    end else if (ram_wr_en) begin
      ram[ram_wr_addr] <= ram_wr_data;
    end
  end
  assign ram_rd_data = ram[ram_rd_addr];

  // Transfer-level reference model: mode 0 idle, 1 awaiting pointer, 2 writing, 3 reading.
  logic [7:0] m_mem [256];
  bit         m_init = 1'b0;
  int         m_mode = 0;
  logic [7:0] m_ptr = 8'h00, m_txd = 8'h00;
  logic       m_txv = 1'b0, m_fetch = 1'b0, m_und = 1'b0, m_wph = 1'b0;

  function automatic logic wp_block(input logic [7:0] p);
`ifdef I2CS_RAM_WP_EN
    return wp && (p >= 8'hF0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!m_init) begin
      for (int i = 0; i < 256; i++) m_mem[i] <= pat(i);
      m_init <= 1'b1;
    end
    if (!rst_ni) begin
      m_mode <= 0; m_ptr <= 8'h00; m_txv <= 1'b0; m_txd <= 8'h00;
      m_fetch <= 1'b0; m_und <= 1'b0; m_wph <= 1'b0;
    end else begin
      m_und <= 1'b0;
      m_wph <= 1'b0;
      if (xfer_start) begin
        m_mode <= xfer_dir ? 3 : 1;
        m_fetch <= xfer_dir;
        m_txv <= 1'b0;
      end else if (xfer_stop) begin
        m_mode <= 0;
        m_txv <= 1'b0;
      end else if (m_mode == 0) begin
        if (tx_req) m_und <= 1'b1;
      end else if (m_mode == 1) begin
        if (rx_valid) begin m_ptr <= rx_data; m_mode <= 2; end
      end else if (m_mode == 2) begin
        if (rx_valid) begin
          if (wp_block(m_ptr)) m_wph <= 1'b1;
          else m_mem[m_ptr] <= rx_data;
          m_ptr <= m_ptr + 8'd1;
        end
      end else if (m_fetch) begin
        m_fetch <= 1'b0;
        m_txv <= 1'b1;
        m_txd <= m_mem[m_ptr];
        if (tx_req) m_und <= 1'b1;
      end else if (tx_req && m_txv) begin
        m_ptr <= m_ptr + 8'd1;
        m_txv <= 1'b0;
        m_fetch <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic exp_we;
    @(negedge clk);
    exp_we = (m_mode == 2) && rx_valid && !xfer_start && !xfer_stop && !wp_block(m_ptr);
    chk("busy", busy, m_mode != 0);
    chk("rx_ready", rx_ready, (m_mode == 1) || (m_mode == 2));
    chk("ptr", ptr, m_ptr);
    chk("rd_addr", ram_rd_addr, m_ptr);
    chk("tx_valid", tx_valid, m_txv);
    chk("tx_data", tx_data, m_txd);
    chk("underrun", tx_underrun, m_und);
    chk("wr_en", ram_wr_en, exp_we);
    if (exp_we) begin
      chk("wr_addr", ram_wr_addr, m_ptr);
      chk("wr_data", ram_wr_data, rx_data);
    end
`ifdef I2CS_RAM_WP_EN
    chk("wp_hit", wp_hit, m_wph);
    if (wp_hit) wp_cnt++;
`endif
  end

  task automatic step(input logic s, input logic d, input logic p, input logic rv,
                      input logic [7:0] rd, input logic tr);
    xfer_start = s; xfer_dir = d; xfer_stop = p; rx_valid = rv; rx_data = rd; tx_req = tr;
    @(posedge clk); #1;
    xfer_start = 1'b0; xfer_stop = 1'b0; rx_valid = 1'b0; tx_req = 1'b0;
  endtask

  task automatic idle();                      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic start_wr();                  step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic start_rd();                  step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic stop();                      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); endtask
  task automatic rx(input logic [7:0] b);     step(1'b0, 1'b0, 1'b0, 1'b1, b, 1'b0);     endtask
  task automatic treq();                      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1); endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ptr", ptr, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;

    // Sequential write with auto-increment.
    start_wr(); rx(8'h10); rx(8'hAA); rx(8'hBB); stop();
    chk("t2_ptr", ptr, 8'h12);
    chk("t2_mem10", ram[8'h10], 8'hAA);
    chk("t2_mem11", ram[8'h11], 8'hBB);

    // Pointer wrap at the top of the RAM.
    start_wr(); rx(8'hFF); rx(8'h11); rx(8'h22); stop();
    chk("t3_ptr", ptr, 8'h01);
    chk("t3_memFF", ram[8'hFF], 8'h11);
    chk("t3_mem00", ram[8'h00], 8'h22);

    // Random read: set pointer, repeated start for read, stream three bytes.
    start_wr(); rx(8'h10); start_rd();
    chk("t4_valid_lo", tx_valid, 1'b0);
    idle();
    chk("t4_valid_hi", tx_valid, 1'b1);
    chk("t4_byte0", tx_data, 8'hAA);
    treq();
    chk("t4_valid_gap", tx_valid, 1'b0);
    chk("t4_ptr11", ptr, 8'h11);
    idle();
    chk("t4_byte1", tx_data, 8'hBB);
    treq(); idle();
    chk("t4_byte2", tx_data, 8'h48);

    // Reset while holding a read byte.
    #3 rst_ni = 1'b0;
    #1;
    chk("t1_busy", busy, 1'b0);
    chk("t1_tx_valid", tx_valid, 1'b0);
    chk("t1_ptr", ptr, 8'h00);
    chk("t1_tx_data", tx_data, 8'h00);
    @(posedge clk); #3 rst_ni = 1'b1;
    @(posedge clk); #1;

    // Early tx_req underruns; stop beats a same-cycle data byte.
    start_rd(); treq();
    chk("t5_underrun", tx_underrun, 1'b1);
    chk("t5_ptr", ptr, 8'h00);
    chk("t5_byte", tx_data, 8'h22);
    idle();
    chk("t5_underrun_clr", tx_underrun, 1'b0);
    stop();
    start_wr(); rx(8'h30);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    chk("t5_mem30", ram[8'h30], 8'h6A);
    chk("t5_idle", busy, 1'b0);
    rx(8'h55);
    chk("t5_idle_rx_ptr", ptr, 8'h30);

`ifdef I2CS_RAM_WP_EN
    wp = 1'b1;
    wp_cnt = 0;
    start_wr(); rx(8'hEF); rx(8'h01); rx(8'h02); rx(8'h03); stop();
    chk("t6_memEF", ram[8'hEF], 8'h01);
    chk("t6_memF0", ram[8'hF0], 8'hAA);
    chk("t6_memF1", ram[8'hF1], 8'hAB);
    chk("t6_ptr", ptr, 8'hF2);
    chk("t6_wp_cnt", wp_cnt, 2);
    wp = 1'b0;
`endif

    repeat (2) idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
